// File: rtl/sobel_pkg.sv
// Shared types and constants for the 3x3 window fetcher: FSM states,
// window geometry, and slot-index to (row, column) helpers.
package sobel_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RDONE = 3'd3,
        MOVE  = 3'd4
    } state_t;

    localparam int WIN_PIXELS  = 9;
    localparam int COL_FETCHES = 3;

    // Window slots are numbered row-major: slot = 3*r + c.
    function automatic logic [1:0] slot_row(input logic [3:0] slot);
        logic [3:0] q;
        q = slot / 4'd3;
        return q[1:0];
    endfunction

    function automatic logic [1:0] slot_col(input logic [3:0] slot);
        logic [3:0] rem;
        rem = slot % 4'd3;
        return rem[1:0];
    endfunction

endpackage

// File: rtl/fetch_addr_gen.sv
// Pixel address generator: base + (row+r)*width + (col+c), wrapping in 16 bits.
// The address is registered on load so it is stable for the whole request cycle.
module fetch_addr_gen (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        load,
    input  logic [9:0]  col,
    input  logic [9:0]  row,
    input  logic [1:0]  r,
    input  logic [1:0]  c,
    input  logic [9:0]  width,
    input  logic [15:0] base,
    output logic [15:0] mem_addr
);

    logic [15:0] addr_next;

    always_comb begin
        addr_next = base + (16'(row) + 16'(r)) * 16'(width) + 16'(col) + 16'(c);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem_addr <= '0;
        end else if (load) begin
            mem_addr <= addr_next;
        end
    end

endmodule

// File: rtl/window_fetch.sv
// 3x3 pixel window fetcher: full-window or right-column refills over a
// single-outstanding read port, plus raster-order window position stepping.
module window_fetch
    import sobel_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        load_initial,
    input  logic        start_9_read,
    input  logic        start_i_read,
    input  logic        start_move,
    input  logic [9:0]  image_width,
    input  logic [9:0]  image_height,
    input  logic [15:0] base_addr,
    output logic        mem_read_en,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    output logic [71:0] window,
    output logic        read_data_done,
    output logic        move_done,
    output logic        all_done,
    output logic        busy
);

    state_t      state_reg;
    logic [9:0]  width_reg;
    logic [9:0]  height_reg;
    logic [15:0] base_reg;
    logic [9:0]  col_reg;
    logic [9:0]  row_reg;
    logic [3:0]  slot_reg;
    logic [3:0]  left_reg;
    logic        mode9_reg;
    logic [7:0]  pix_reg [WIN_PIXELS];

    logic        addr_load;
    logic [3:0]  slot_next;

    // Select the slot of the fetch about to be issued so its address
    // lands in the address register on the same edge as mem_read_en.
    always_comb begin
        addr_load = 1'b0;
        slot_next = slot_reg;
        case (state_reg)
            IDLE: begin
                if (!load_initial) begin
                    if (start_9_read) begin
                        addr_load = 1'b1;
                        slot_next = 4'd0;
                    end else if (start_i_read) begin
                        addr_load = 1'b1;
                        slot_next = 4'd2;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid && left_reg > 4'd1) begin
                    addr_load = 1'b1;
                    slot_next = slot_reg + (mode9_reg ? 4'd1 : 4'd3);
                end
            end
            default: ;
        endcase
    end

    fetch_addr_gen u_addr (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (addr_load),
        .col      (col_reg),
        .row      (row_reg),
        .r        (slot_row(slot_next)),
        .c        (slot_col(slot_next)),
        .width    (width_reg),
        .base     (base_reg),
        .mem_addr (mem_addr)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= IDLE;
            width_reg      <= '0;
            height_reg     <= '0;
            base_reg       <= '0;
            col_reg        <= '0;
            row_reg        <= '0;
            slot_reg       <= '0;
            left_reg       <= '0;
            mode9_reg      <= 1'b0;
            mem_read_en    <= 1'b0;
            read_data_done <= 1'b0;
            move_done      <= 1'b0;
            all_done       <= 1'b0;
            for (int i = 0; i < WIN_PIXELS; i++) begin
                pix_reg[i] <= '0;
            end
        end else begin
            mem_read_en    <= 1'b0;
            read_data_done <= 1'b0;
            move_done      <= 1'b0;
            all_done       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load_initial) begin
                        width_reg  <= image_width;
                        height_reg <= image_height;
                        base_reg   <= base_addr;
                        col_reg    <= '0;
                        row_reg    <= '0;
                    end else if (start_9_read) begin
                        mode9_reg   <= 1'b1;
                        slot_reg    <= 4'd0;
                        left_reg    <= 4'(WIN_PIXELS);
                        mem_read_en <= 1'b1;
                        state_reg   <= ISSUE;
                    end else if (start_i_read) begin
                        pix_reg[0]  <= pix_reg[1];
                        pix_reg[1]  <= pix_reg[2];
                        pix_reg[3]  <= pix_reg[4];
                        pix_reg[4]  <= pix_reg[5];
                        pix_reg[6]  <= pix_reg[7];
                        pix_reg[7]  <= pix_reg[8];
                        mode9_reg   <= 1'b0;
                        slot_reg    <= 4'd2;
                        left_reg    <= 4'(COL_FETCHES);
                        mem_read_en <= 1'b1;
                        state_reg   <= ISSUE;
                    end else if (start_move) begin
                        // Width/height below 3 wrap the compare bound to a large
                        // value, so col just counts on and nothing stalls.
                        if (col_reg < width_reg - 10'd3) begin
                            col_reg <= col_reg + 10'd1;
                        end else begin
                            col_reg <= '0;
                            if (row_reg >= height_reg - 10'd3) begin
                                row_reg  <= '0;
                                all_done <= 1'b1;
                            end else begin
                                row_reg <= row_reg + 10'd1;
                            end
                        end
                        move_done <= 1'b1;
                        state_reg <= MOVE;
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        pix_reg[slot_reg] <= mem_rdata;
                        left_reg          <= left_reg - 4'd1;
                        if (left_reg > 4'd1) begin
                            slot_reg    <= slot_next;
                            mem_read_en <= 1'b1;
                            state_reg   <= ISSUE;
                        end else begin
                            read_data_done <= 1'b1;
                            state_reg      <= RDONE;
                        end
                    end
                end
                RDONE: begin
                    state_reg <= IDLE;
                end
                MOVE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg != IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < WIN_PIXELS; gi++) begin : g_pack
            assign window[gi*8 +: 8] = pix_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_window_fetch.sv
// Directed bench for window_fetch: behavioural pixel memory with fixed or
// random latency, a window/position model, and immediate-assertion checks.
module tb_window_fetch;

    logic        clk;
    logic        n_rst;
    logic        load_initial;
    logic        start_9_read;
    logic        start_i_read;
    logic        start_move;
    logic [9:0]  image_width;
    logic [9:0]  image_height;
    logic [15:0] base_addr;
    logic        mem_read_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic [71:0] window;
    logic        read_data_done;
    logic        move_done;
    logic        all_done;
    logic        busy;

    window_fetch dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .load_initial   (load_initial),
        .start_9_read   (start_9_read),
        .start_i_read   (start_i_read),
        .start_move     (start_move),
        .image_width    (image_width),
        .image_height   (image_height),
        .base_addr      (base_addr),
        .mem_read_en    (mem_read_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_rvalid     (mem_rvalid),
        .window         (window),
        .read_data_done (read_data_done),
        .move_done      (move_done),
        .all_done       (all_done),
        .busy           (busy)
    );

    int checks = 0;
    int failures = 0;

    // memory responder state
    int          pend_cnt;
    logic [15:0] pend_addr;
    int          overlaps;
    bit          rand_lat = 0;
    bit          spurious = 0;
    int          fixed_lat = 1;
    logic [15:0] addr_log [$];

    // model
    logic [7:0] model [9];
    int w_m, h_m, base_m, col_m, row_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [15:0] exp_addr(input int s);
        return 16'(base_m + (row_m + s / 3) * w_m + col_m + s % 3);
    endfunction

    function automatic logic [71:0] model_win();
        logic [71:0] v;
        for (int i = 0; i < 9; i++) v[i*8 +: 8] = model[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        pend_cnt   = 0;
        overlaps   = 0;
        forever begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pix(pend_addr);
                end
            end else if (spurious && $urandom_range(0, 3) == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 8'hEE;
            end
            if (mem_read_en) begin
                if (pend_cnt > 0) overlaps++;
                pend_addr = mem_addr;
                addr_log.push_back(mem_addr);
                pend_cnt = rand_lat ? int'($urandom_range(1, 5)) : fixed_lat;
            end
        end
    end

    // Pulse a start in cycle 0, then count cycles until read_data_done.
    task automatic run_read(input bit nine, input bit with_move, input bit pokes,
                            output int n, output bit done, output bit saw_move,
                            output bit busy1);
        addr_log.delete();
        done = 0; saw_move = 0; busy1 = 0; n = 0;
        @(posedge clk); #1;
        start_9_read = nine;
        start_i_read = !nine;
        start_move   = with_move;
        while (!done && n < 400) begin
            @(posedge clk); #1;
            n++;
            start_9_read = 1'b0;
            start_i_read = 1'b0;
            start_move   = 1'b0;
            if (n == 1) busy1 = busy;
            if (pokes && n == 5) begin
                start_move   = 1'b1;
                start_9_read = 1'b1;
            end
            if (move_done) saw_move = 1;
            if (read_data_done) done = 1;
        end
    endtask

    task automatic check_read(input bit nine, input string tag);
        int cnt;
        int s;
        logic [15:0] a;
        cnt = nine ? 9 : 3;
        if (!nine) begin
            model[0] = model[1]; model[1] = model[2];
            model[3] = model[4]; model[4] = model[5];
            model[6] = model[7]; model[7] = model[8];
        end
        chk({tag, "_count"}, 72'(addr_log.size()), 72'(cnt));
        for (int i = 0; i < cnt; i++) begin
            s = nine ? i : 3 * i + 2;
            a = exp_addr(s);
            model[s] = pix(a);
            if (i < addr_log.size()) chk({tag, "_addr"}, 72'(addr_log[i]), 72'(a));
        end
        chk({tag, "_window"}, window, model_win());
    endtask

    task automatic do_move(output bit md, output bit ad);
        @(posedge clk); #1;
        start_move = 1'b1;
        @(posedge clk); #1;
        start_move = 1'b0;
        md = move_done;
        ad = all_done;
        @(posedge clk); #1;
    endtask

    task automatic do_load(input int w, input int h, input int b);
        @(posedge clk); #1;
        load_initial = 1'b1;
        image_width  = 10'(w);
        image_height = 10'(h);
        base_addr    = 16'(b);
        @(posedge clk); #1;
        load_initial = 1'b0;
        w_m = w; h_m = h; base_m = b; col_m = 0; row_m = 0;
    endtask

    initial begin
        int n;
        bit done, saw_move, busy1, md, ad, exp_ad;

        n_rst = 1'b0;
        load_initial = 1'b0;
        start_9_read = 1'b0;
        start_i_read = 1'b0;
        start_move   = 1'b0;
        image_width  = '0;
        image_height = '0;
        base_addr    = '0;
        for (int i = 0; i < 9; i++) model[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", mem_read_en, 0);
        chk("rst_window", window, 0);
        chk("rst_done", {read_data_done, move_done, all_done}, 0);
        @(negedge clk);
        n_rst = 1'b1;

        // full window at (0,0), 1-cycle memory
        do_load(8, 6, 'h1000);
        chk("load_idle", busy, 0);
        run_read(1, 0, 0, n, done, saw_move, busy1);
        $display("read9 latency=%0d addrs=%0d", n, addr_log.size());
        chk("r9_busy", busy1, 1);
        chk("r9_latency", n, 19);
        chk("r9_addr3", 72'(addr_log[3]), 72'h1008);
        chk("r9_addr8", 72'(addr_log[8]), 72'h1012);
        check_read(1, "r9");

        // step to col=1, then shift in a new right column
        do_move(md, ad);
        $display("move col=%0d row=%0d move_done=%0b all_done=%0b", col_m, row_m, md, ad);
        col_m = 1;
        chk("mv1_done", md, 1);
        chk("mv1_all", ad, 0);
        run_read(0, 0, 0, n, done, saw_move, busy1);
        $display("readI latency=%0d addrs=%0d", n, addr_log.size());
        chk("ri_latency", n, 7);
        check_read(0, "ri");

        // raster sweep over 8x6: 6 columns x 4 rows = 24 positions
        do_load(8, 6, 'h1000);
        for (int k = 1; k <= 24; k++) begin
            exp_ad = (col_m == w_m - 3) && (row_m == h_m - 3);
            do_move(md, ad);
            if (col_m < w_m - 3) col_m++;
            else begin
                col_m = 0;
                if (row_m >= h_m - 3) row_m = 0; else row_m++;
            end
            $display("move %0d -> col=%0d row=%0d move_done=%0b all_done=%0b", k, col_m, row_m, md, ad);
            chk("sweep_move_done", md, 1);
            chk("sweep_all_done", ad, exp_ad);
            if (k == 6 || k == 24) begin
                run_read(1, 0, 0, n, done, saw_move, busy1);
                $display("sweep read at col=%0d row=%0d first=%0h", col_m, row_m, addr_log[0]);
                chk("sweep_read_done", done, 1);
                check_read(1, "sweep");
            end
        end

        // random latency with spurious strobes in idle
        rand_lat = 1;
        spurious = 1;
        repeat (10) @(posedge clk);
        do_move(md, ad);
        col_m = 1;
        run_read(1, 0, 0, n, done, saw_move, busy1);
        $display("rand read9 cycles=%0d", n);
        chk("rnd9_done", done, 1);
        check_read(1, "rnd9");
        repeat (7) @(posedge clk);
        run_read(0, 0, 0, n, done, saw_move, busy1);
        $display("rand readI cycles=%0d", n);
        chk("rndI_done", done, 1);
        check_read(0, "rndI");
        rand_lat = 0;
        spurious = 0;
        repeat (8) @(posedge clk);

        // simultaneous read+move, plus pokes while busy
        run_read(1, 1, 1, n, done, saw_move, busy1);
        repeat (4) @(posedge clk);
        #1;
        $display("simul read latency=%0d saw_move=%0b addrs=%0d", n, saw_move, addr_log.size());
        chk("sim_latency", n, 19);
        chk("sim_no_move", saw_move, 0);
        chk("sim_busy", busy, 0);
        check_read(1, "sim");

        // reset during WAIT of fifth fetch; late strobe must be ignored
        fixed_lat = 3;
        addr_log.delete();
        @(posedge clk); #1;
        start_9_read = 1'b1;
        @(posedge clk); #1;
        start_9_read = 1'b0;
        n = 0;
        while (addr_log.size() < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_reach5", 72'(addr_log.size()), 72'd5);
        @(posedge clk); #2;
        n_rst = 1'b0;
        #1;
        $display("mid-fetch reset busy=%0b rd_en=%0b window=%0h", busy, mem_read_en, window);
        chk("mrst_busy", busy, 0);
        chk("mrst_rd_en", mem_read_en, 0);
        chk("mrst_window", window, 0);
        chk("mrst_done", {read_data_done, move_done, all_done}, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        $display("after late strobe window=%0h busy=%0b addrs=%0d", window, busy, addr_log.size());
        chk("late_window", window, 0);
        chk("late_busy", busy, 0);
        chk("late_no_issue", 72'(addr_log.size()), 72'd5);
        chk("overlap", overlaps, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
